jam_perm_gen: RTL and testbench

//   Lexicographic permutation engine for the job-assignment machine (JAM).

---
 rtl/jam_perm_gen_if.sv | 27 ++
 rtl/jam_perm_gen.sv | 121 ++++++++++++
 tb/tb_jam_perm_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jam_perm_gen_if.sv
// Handshake bundle between the JAM permutation engine and the cost accumulator.
// The engine drives perm/status; the consumer drives start and perm_ready.
interface jam_perm_gen_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic               start;
  logic [N*IDX_W-1:0] perm;
  logic               perm_valid;
  logic               perm_ready;
  logic               perm_last;
  logic [15:0]        perm_index;
  logic               busy;
  logic               done;

  modport master (
    input  start, perm_ready,
    output perm, perm_valid, perm_last,
    output perm_index, busy, done
  );

  modport slave (
    output start, perm_ready,
    input  perm, perm_valid, perm_last,
    input  perm_index, busy, done
  );
endinterface

// File: rtl/jam_perm_gen.sv
// Lexicographic permutation engine: pivot, successor swap, then
// an in-place suffix reversal one exchange per cycle.
module jam_perm_gen #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input logic            CLK,
  input logic            RST,
  jam_perm_gen_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, OUT, FIND, SWAP, REV, DONE
  } state_t;

  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] p [N];
  logic [IDX_W-1:0] piv_q, suc_q;
  logic [IDX_W-1:0] lo_q, hi_q;
  logic [IDX_W-1:0] piv_c, suc_c;
  logic             has_piv;
  logic [15:0]      idx_q;
  logic             xfer;
  logic             rev_end;

  always_comb begin
    piv_c   = '0;
    has_piv = 1'b0;
    for (int k = 0; k < N-1; k++) begin
      if (p[k] < p[k+1]) begin
        piv_c   = IDX_W'(k);
        has_piv = 1'b1;
      end
    end
    suc_c = '0;
    for (int k = 1; k < N; k++) begin
      if (IDX_W'(k) > piv_c && p[k] > p[piv_c])
        suc_c = IDX_W'(k);
    end
  end

  assign xfer    = bus.perm_valid && bus.perm_ready;
  // lo < hi always holds inside REV, so lo+1 cannot overflow
  assign rev_end = (lo_q + ONE) >= (hi_q - ONE);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = OUT;
      OUT: begin
        if (xfer)
          state_d = bus.perm_last ? DONE : FIND;
      end
      FIND: state_d = SWAP;
      SWAP: state_d = ((piv_q + ONE) < LAST) ? REV : OUT;
      REV:  if (rev_end) state_d = OUT;
      DONE: if (bus.start) state_d = OUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < N; k++) p[k] <= IDX_W'(k);
      idx_q <= '0;
      piv_q <= '0;
      suc_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            for (int k = 0; k < N; k++) p[k] <= IDX_W'(k);
            idx_q <= '0;
          end
        end
        OUT: begin
          if (xfer && !bus.perm_last)
            idx_q <= idx_q + 16'd1;
        end
        FIND: begin
          piv_q <= piv_c;
          suc_q <= suc_c;
        end
        SWAP: begin
          p[piv_q] <= p[suc_q];
          p[suc_q] <= p[piv_q];
          lo_q     <= piv_q + ONE;
          hi_q     <= LAST;
        end
        REV: begin
          p[lo_q] <= p[hi_q];
          p[hi_q] <= p[lo_q];
          lo_q    <= lo_q + ONE;
          hi_q    <= hi_q - ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.perm = '0;
    for (int k = 0; k < N; k++)
      bus.perm[k*IDX_W +: IDX_W] = p[k];
  end

  assign bus.perm_valid = (state_q == OUT);
  assign bus.perm_last  = !has_piv;
  assign bus.perm_index = idx_q;
  assign bus.busy       = !(state_q inside {IDLE, DONE});
  assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_jam_perm_gen.sv
// Bench for jam_perm_gen: N=8 engine for sequencing/stall/reset cases,
// N=5 engine for a complete sweep; reference built from factoradic ranks.
module tb_jam_perm_gen;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   fails  = 0;

  always #5 CLK = ~CLK;

  jam_perm_gen_if #(.N(8), .IDX_W(3)) b8 ();
  jam_perm_gen_if #(.N(5), .IDX_W(3)) b5 ();

  jam_perm_gen #(.N(8), .IDX_W(3)) u_big (
    .CLK(CLK), .RST(RST), .bus(b8)
  );
  jam_perm_gen #(.N(5), .IDX_W(3)) u_small (
    .CLK(CLK), .RST(RST), .bus(b5)
  );

  typedef struct {
    int          idx;
    logic [23:0] rd;
    int          gap;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic int fact(input int n);
    int f = 1;
    for (int k = 2; k <= n; k++) f *= k;
    return f;
  endfunction

  // rank -> permutation, worker 0 in the most significant digit
  function automatic logic [23:0] model(input int n,
                                        input int idx);
    int pool [8];
    int r = idx;
    logic [23:0] v = '0;
    for (int k = 0; k < 8; k++) pool[k] = k;
    for (int pos = 0; pos < n; pos++) begin
      int f, d;
      f = fact(n - 1 - pos);
      d = r / f;
      r = r % f;
      v = (v << 3) | 24'(pool[d]);
      for (int k = d; k < 7; k++) pool[k] = pool[k+1];
    end
    return v;
  endfunction

  function automatic logic [23:0] rd(input logic [23:0] pk,
                                    input int n);
    logic [23:0] v = '0;
    for (int k = 0; k < n; k++)
      v = (v << 3) | 24'(pk[3*k +: 3]);
    return v;
  endfunction

  function automatic int pivot(input logic [23:0] v,
                               input int n);
    int pv = -1;
    for (int k = 0; k < n - 1; k++)
      if (v[3*(n-1-k) +: 3] < v[3*(n-2-k) +: 3]) pv = k;
    return pv;
  endfunction

  task automatic wait_valid(input bit sm, output int gap);
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (!(sm ? b5.perm_valid : b8.perm_valid)
               && gap < 40);
    chk("valid_timeout",
        32'(sm ? b5.perm_valid : b8.perm_valid), 32'd1);
  endtask

  task automatic chk_reset8(input string nm);
    chk({nm, "_valid"}, 32'(b8.perm_valid), 0);
    chk({nm, "_busy"},  32'(b8.busy), 0);
    chk({nm, "_done"},  32'(b8.done), 0);
    chk({nm, "_idx"},   32'(b8.perm_index), 0);
    chk({nm, "_last"},  32'(b8.perm_last), 0);
    chk({nm, "_perm"},  32'(rd(b8.perm, 8)),
        32'(24'o01234567));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          gap;
    int          exp_i;
    int          n_x;
    logic [23:0] v;
    logic [23:0] prev;

    tbl[0] = '{0, 24'o01234567, 1};
    tbl[1] = '{1, 24'o01234576, 3};
    tbl[2] = '{2, 24'o01234657, 4};
    tbl[3] = '{3, 24'o01234675, 3};
    tbl[4] = '{4, 24'o01234756, 4};
    tbl[5] = '{5, 24'o01234765, 3};
    tbl[6] = '{6, 24'o01235467, 4};

    RST = 1'b1;
    b8.start = 1'b0;
    b8.perm_ready = 1'b0;
    b5.start = 1'b0;
    b5.perm_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk_reset8("rst");
    chk("rst_small_perm", 32'(rd(24'(b5.perm), 5)),
        32'(24'o01234));

    // first steps and backpressure at index 5
    b8.perm_ready = 1'b1;
    b8.start = 1'b1;
    for (int r = 0; r < 7; r++) begin
      wait_valid(0, gap);
      b8.start = 1'b0;
      chk("seq_gap", 32'(gap), 32'(tbl[r].gap));
      chk("seq_idx", 32'(b8.perm_index), 32'(tbl[r].idx));
      chk("seq_perm", 32'(rd(b8.perm, 8)), 32'(tbl[r].rd));
      if (r == 5) begin
        b8.perm_ready = 1'b0;
        repeat (10) begin
          @(negedge CLK);
          chk("bp_valid", 32'(b8.perm_valid), 1);
          chk("bp_idx", 32'(b8.perm_index), 5);
          chk("bp_perm", 32'(rd(b8.perm, 8)),
              32'(tbl[5].rd));
        end
        b8.perm_ready = 1'b1;
      end
    end

    // random ready against the rank model, through the deep pivot
    exp_i = 6;
    while (exp_i < 5041) begin
      v = model(8, exp_i);
      chk("rnd_idx", 32'(b8.perm_index), 32'(exp_i));
      chk("rnd_perm", 32'(rd(b8.perm, 8)), 32'(v));
      chk("rnd_last", 32'(b8.perm_last), 0);
      b8.perm_ready = ($urandom_range(3) != 0);
      while (!b8.perm_ready) begin
        @(negedge CLK);
        chk("stall_valid", 32'(b8.perm_valid), 1);
        chk("stall_idx", 32'(b8.perm_index), 32'(exp_i));
        chk("stall_perm", 32'(rd(b8.perm, 8)), 32'(v));
        b8.perm_ready = ($urandom_range(3) != 0);
      end
      wait_valid(0, gap);
      exp_i++;
      chk("rnd_gap", 32'(gap),
          32'(3 + (7 - pivot(v, 8)) / 2));
      if (exp_i == 5040) begin
        chk("deep_gap", 32'(gap), 6);
        chk("deep_perm", 32'(rd(b8.perm, 8)),
            32'(24'o10234567));
        chk("deep_idx", 32'(b8.perm_index), 5040);
      end
    end

    // reset while reversing the suffix of 10234576
    chk("pre_rev_perm", 32'(rd(b8.perm, 8)),
        32'(24'o10234576));
    b8.perm_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rev_busy", 32'(b8.busy), 1);
    chk("rev_valid", 32'(b8.perm_valid), 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset8("mid_rst");
    @(negedge CLK);
    chk("idle_hold_valid", 32'(b8.perm_valid), 0);
    b8.perm_ready = 1'b0;
    b8.start = 1'b1;
    wait_valid(0, gap);
    b8.start = 1'b0;
    chk("restart_gap", 32'(gap), 1);
    chk("restart_idx", 32'(b8.perm_index), 0);
    chk("restart_perm", 32'(rd(b8.perm, 8)),
        32'(24'o01234567));

    // full sweep on the 5-worker engine
    b5.perm_ready = 1'b1;
    b5.start = 1'b1;
    wait_valid(1, gap);
    b5.start = 1'b0;
    chk("s_first_gap", 32'(gap), 1);
    prev = '0;
    n_x = 0;
    for (int e = 0; e < 120; e++) begin
      v = model(5, e);
      chk("s_idx", 32'(b5.perm_index), 32'(e));
      chk("s_perm", 32'(rd(24'(b5.perm), 5)), 32'(v));
      chk("s_last", 32'(b5.perm_last), 32'(e == 119));
      if (e > 0)
        chk("s_order",
            32'(rd(24'(b5.perm), 5) > prev), 1);
      prev = rd(24'(b5.perm), 5);
      n_x++;
      if (e == 60) b5.start = 1'b1;
      if (e == 119) break;
      wait_valid(1, gap);
      b5.start = 1'b0;
      chk("s_gap", 32'(gap),
          32'(3 + (4 - pivot(v, 5)) / 2));
    end
    @(negedge CLK);
    chk("s_count", 32'(n_x), 120);
    chk("s_done", 32'(b5.done), 1);
    chk("s_busy", 32'(b5.busy), 0);
    chk("s_valid", 32'(b5.perm_valid), 0);
    chk("s_final_idx", 32'(b5.perm_index), 119);
    chk("s_final_perm", 32'(rd(24'(b5.perm), 5)),
        32'(24'o43210));
    repeat (3) @(negedge CLK);
    chk("s_done_hold", 32'(b5.done), 1);
    b5.start = 1'b1;
    wait_valid(1, gap);
    b5.start = 1'b0;
    chk("s_again_gap", 32'(gap), 1);
    chk("s_again_done", 32'(b5.done), 0);
    chk("s_again_idx", 32'(b5.perm_index), 0);
    chk("s_again_perm", 32'(rd(24'(b5.perm), 5)),
        32'(24'o01234));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
